max7219_settings: RTL and testbench
===================================

MAX7219_SETTINGS -- requirements
Module: max7219_settings

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Ports (clock and reset first):
- i_clk  in  1  system clock (~50 MHz), rising-edge
- i_reset  in  1  asynchronous active-high reset
- i_stb  in  1  request strobe, sampled only while idle
- o_busy  out  1  operation in progress
- o_ack  out  1  last operation completed
- i_digit  in  3  digit index 0-7
- i_segment  in  8  digit data
- i_write_config  in  1  1 = config sequence, 0 = digit write
- i_decode_mode  in  8  decode-mode register value
- i_intensity  in  4  intensity value
- i_scan_limit  in  3  scan-limit value
- i_enable  in  1  1 = display on (shutdown register bit 0)
- i_display_test  in  1  display-test bit
- i_next  in  1  downstream serial driver ack pulse
- o_write  out  1  downstream write strobe
- o_addr  out  4  downstream register address
- o_data  out  8  downstream register data

Function
REQ-003 SHALL implement the states IDLE, ISSUE and WAIT.
REQ-004 IDLE with i_stb=1 at a clock edge SHALL capture all data and config inputs, set o_busy=1, clear o_ack and enter ISSUE.
REQ-005 i_stb SHALL be ignored while o_busy=1.
REQ-006 Digit write SHALL be a single register write with o_addr={1'b0,i_digit}+1 (range 1-8) and o_data=i_segment.
REQ-007 Config write SHALL issue these register writes in order:
- 0x9 = decode_mode
- 0xA = {4'h0,intensity}
- 0xB = {5'h0,scan_limit}
- 0xC = {7'h0,enable}
- 0xF = {7'h0,display_test} (see REQ-017)
REQ-008 ISSUE SHALL drive o_write=1 for exactly one cycle and then enter WAIT.
REQ-009 o_addr/o_data SHALL hold the current write's values from ISSUE until i_next is sampled high.
REQ-010 In WAIT, when i_next=1 at an edge: if writes remain, advance to the next write and return to ISSUE; otherwise go to IDLE with o_busy=0 and o_ack=1 on that same edge.
REQ-011 i_next outside WAIT SHALL be ignored.
REQ-012 o_ack SHALL remain 1 until the next accepted i_stb or reset.
REQ-013 Captured inputs SHALL be used for the entire operation; input changes mid-operation SHALL have no effect.
REQ-014 Latency: o_write SHALL rise on the edge after stb acceptance and on the edge after each non-final i_next.

Reset
REQ-015 Reset SHALL force IDLE, o_busy=0, o_ack=0, o_write=0, o_addr=0 and o_data=0, asynchronously and mid-operation; any sequence in progress SHALL be abandoned.
REQ-016 After reset release the block SHALL accept i_stb on the first clock edge.

Configuration
REQ-017 Macro MAX7219_DISPLAY_TEST_EN:
- Defined: config sequence is 5 writes including 0xF.
- Undefined: config sequence is 4 writes (0x9-0xC), i_display_test is unused, and o_ack follows the 0xC ack.

Verification
REQ-018 Reset, then config write with decode=0x0F, intensity=7, scan=5, enable=1, test=0, downstream driver attached -> writes 0x9/0x0F, 0xA/0x07, 0xB/0x05, 0xC/0x01, 0xF/0x00 (0xF only with macro); o_busy falls within 160 cycles; o_ack=1.
REQ-019 Digit writes (0,0xF), (1,0x7), (2,0x5), (3,0x1) -> o_addr=1,2,3,4 and o_data=0x0F,0x07,0x05,0x01, stable for the whole busy period; o_ack=1 within 64 cycles.
REQ-020 i_stb held high throughout an operation -> exactly one operation executed; o_write pulse count = 1 (digit) or 5/4 (config).
REQ-021 Change i_segment and i_intensity after acceptance -> o_data still shows the captured values.
REQ-022 Assert i_reset during the config WAIT of 0xB -> all outputs 0 immediately; a following digit write (7,0x3) -> addr 8, data 0x03.
REQ-023 Pulse i_next while IDLE -> no state or output change.

Source files
------------

// File: rtl/max7219_settings.sv
// MAX7219 register sequencer: turns a digit write or a full config request into
// single register writes for a downstream serial driver. Macro MAX7219_DISPLAY_TEST_EN adds the 0xF write.
module max7219_settings (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_stb,
    output logic       o_busy,
    output logic       o_ack,
    input  logic [2:0] i_digit,
    input  logic [7:0] i_segment,
    input  logic       i_write_config,
    input  logic [7:0] i_decode_mode,
    input  logic [3:0] i_intensity,
    input  logic [2:0] i_scan_limit,
    input  logic       i_enable,
    input  logic       i_display_test,
    input  logic       i_next,
    output logic       o_write,
    output logic [3:0] o_addr,
    output logic [7:0] o_data
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

`ifdef MAX7219_DISPLAY_TEST_EN
    localparam logic [2:0] LAST_CFG_STEP = 3'd4;
`else
    localparam logic [2:0] LAST_CFG_STEP = 3'd3;
`endif

    state_t     state_reg;
    logic [2:0] step_reg;
    logic       cfg_reg;
    logic [7:0] decode_reg;
    logic [3:0] intensity_reg;
    logic [2:0] scan_reg;
    logic       enable_reg;
    logic       test_reg;
    logic       busy_reg;
    logic       ack_reg;
    logic       write_reg;
    logic [3:0] addr_reg;
    logic [7:0] data_reg;
    logic [2:0] last_step;

`ifndef MAX7219_DISPLAY_TEST_EN
    wire unused_display_test = i_display_test;
`endif

    // Config step index -> MAX7219 register address.
    function automatic logic [3:0] cfg_addr(input logic [2:0] step);
        case (step)
            3'd0:    cfg_addr = 4'h9;
            3'd1:    cfg_addr = 4'hA;
            3'd2:    cfg_addr = 4'hB;
            3'd3:    cfg_addr = 4'hC;
            default: cfg_addr = 4'hF;
        endcase
    endfunction

    function automatic logic [7:0] cfg_data(
        input logic [2:0] step,
        input logic [7:0] decode,
        input logic [3:0] intensity,
        input logic [2:0] scan,
        input logic       enable,
        input logic       test
    );
        case (step)
            3'd0:    cfg_data = decode;
            3'd1:    cfg_data = {4'h0, intensity};
            3'd2:    cfg_data = {5'h0, scan};
            3'd3:    cfg_data = {7'h0, enable};
            default: cfg_data = {7'h0, test};
        endcase
    endfunction

    assign last_step = cfg_reg ? LAST_CFG_STEP : 3'd0;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_reg     <= IDLE;
            step_reg      <= 3'd0;
            cfg_reg       <= 1'b0;
            decode_reg    <= 8'h00;
            intensity_reg <= 4'h0;
            scan_reg      <= 3'd0;
            enable_reg    <= 1'b0;
            test_reg      <= 1'b0;
            busy_reg      <= 1'b0;
            ack_reg       <= 1'b0;
            write_reg     <= 1'b0;
            addr_reg      <= 4'h0;
            data_reg      <= 8'h00;
        end else begin
            case (state_reg)
                IDLE: begin
                    write_reg <= 1'b0;
                    if (i_stb) begin
                        cfg_reg       <= i_write_config;
                        decode_reg    <= i_decode_mode;
                        intensity_reg <= i_intensity;
                        scan_reg      <= i_scan_limit;
                        enable_reg    <= i_enable;
`ifdef MAX7219_DISPLAY_TEST_EN
                        test_reg      <= i_display_test;
`else
                        test_reg      <= 1'b0;
`endif
                        step_reg      <= 3'd0;
                        busy_reg      <= 1'b1;
                        ack_reg       <= 1'b0;
                        // First write's address/data are loaded now so they are
                        // stable for the whole operation, not just from ISSUE on.
                        if (i_write_config) begin
                            addr_reg <= 4'h9;
                            data_reg <= i_decode_mode;
                        end else begin
                            addr_reg <= {1'b0, i_digit} + 4'd1;
                            data_reg <= i_segment;
                        end
                        state_reg <= ISSUE;
                    end
                end
                ISSUE: begin
                    write_reg <= 1'b1;
                    state_reg <= WAIT;
                end
                WAIT: begin
                    write_reg <= 1'b0;
                    if (i_next) begin
                        if (step_reg == last_step) begin
                            busy_reg  <= 1'b0;
                            ack_reg   <= 1'b1;
                            state_reg <= IDLE;
                        end else begin
                            step_reg  <= step_reg + 3'd1;
                            addr_reg  <= cfg_addr(step_reg + 3'd1);
                            data_reg  <= cfg_data(step_reg + 3'd1, decode_reg, intensity_reg,
                                                  scan_reg, enable_reg, test_reg);
                            state_reg <= ISSUE;
                        end
                    end
                end
                default: begin
                    write_reg <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign o_busy  = busy_reg;
    assign o_ack   = ack_reg;
    assign o_write = write_reg;
    assign o_addr  = addr_reg;
    assign o_data  = data_reg;

endmodule

// File: tb/tb_max7219_settings.sv
// Directed table-driven bench for max7219_settings with a simple downstream driver model
// that acks each write a few cycles later; honours MAX7219_DISPLAY_TEST_EN.
module tb_max7219_settings;

`ifdef MAX7219_DISPLAY_TEST_EN
    localparam int NCFG = 5;
`else
    localparam int NCFG = 4;
`endif

    logic       i_clk = 1'b0;
    logic       i_reset;
    logic       i_stb;
    logic [2:0] i_digit;
    logic [7:0] i_segment;
    logic       i_write_config;
    logic [7:0] i_decode_mode;
    logic [3:0] i_intensity;
    logic [2:0] i_scan_limit;
    logic       i_enable;
    logic       i_display_test;
    logic       i_next;
    logic       o_busy, o_ack, o_write;
    logic [3:0] o_addr;
    logic [7:0] o_data;

    max7219_settings dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_stb(i_stb), .o_busy(o_busy), .o_ack(o_ack),
        .i_digit(i_digit), .i_segment(i_segment), .i_write_config(i_write_config),
        .i_decode_mode(i_decode_mode), .i_intensity(i_intensity), .i_scan_limit(i_scan_limit),
        .i_enable(i_enable), .i_display_test(i_display_test), .i_next(i_next),
        .o_write(o_write), .o_addr(o_addr), .o_data(o_data)
    );

    always #5 i_clk = ~i_clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Downstream driver model: logs each write pulse, acks it 3 cycles later,
    // and checks that addr/data did not move in between.
    logic [3:0] log_addr[$];
    logic [7:0] log_data[$];
    int         pending;
    int         stable_bad;
    logic       manual_next;

    initial begin
        i_next = 1'b0;
        pending = 0;
        stable_bad = 0;
        manual_next = 1'b0;
        forever begin
            @(negedge i_clk);
            i_next = manual_next;
            if (i_reset) begin
                pending = 0;
            end else if (pending > 0) begin
                pending--;
                if (pending == 0) begin
                    if (o_addr !== log_addr[$] || o_data !== log_data[$]) stable_bad++;
                    i_next = 1'b1;
                end
            end else if (o_write === 1'b1) begin
                log_addr.push_back(o_addr);
                log_data.push_back(o_data);
                pending = 3;
            end
        end
    end

    typedef struct {
        logic        cfg;
        logic [2:0]  digit;
        logic [7:0]  segment;
        logic [7:0]  decode;
        logic [3:0]  intensity;
        logic [2:0]  scan;
        logic        en;
        logic        test;
        int          n;
        logic [19:0] ea;
        logic [39:0] ed;
    } vec_t;

    function automatic vec_t mk(input logic cfg, input logic [2:0] dg, input logic [7:0] sg,
                                input logic [7:0] dc, input logic [3:0] it, input logic [2:0] sc,
                                input logic en, input logic ts, input int n,
                                input logic [19:0] ea, input logic [39:0] ed);
        vec_t v;
        v.cfg = cfg; v.digit = dg; v.segment = sg; v.decode = dc; v.intensity = it;
        v.scan = sc; v.en = en; v.test = ts; v.n = n; v.ea = ea; v.ed = ed;
        return v;
    endfunction

    // Apply one request at the current negedge, scramble inputs after acceptance,
    // wait for completion and compare the logged writes.
    task automatic run_op(input vec_t v, input bit hold, input string tag);
        int  bound;
        int  digit_bad;
        bit  done;
        logic [3:0] ea;
        logic [7:0] ed;
        log_addr.delete();
        log_data.delete();
        stable_bad = 0;
        digit_bad = 0;
        done = 0;
        bound = (v.n == 1) ? 64 : 160;
        i_write_config = v.cfg; i_digit = v.digit; i_segment = v.segment;
        i_decode_mode = v.decode; i_intensity = v.intensity; i_scan_limit = v.scan;
        i_enable = v.en; i_display_test = v.test;
        i_stb = 1'b1;
        @(negedge i_clk);
        if (!hold) i_stb = 1'b0;
        i_write_config = ~v.cfg; i_digit = v.digit + 3'd1; i_segment = ~v.segment;
        i_decode_mode = ~v.decode; i_intensity = ~v.intensity; i_scan_limit = ~v.scan;
        i_enable = ~v.en; i_display_test = ~v.test;
        check({tag, " busy_after_stb"}, o_busy, 1'b1);
        for (int c = 0; c < bound; c++) begin
            if (o_busy !== 1'b1) begin
                done = 1;
                i_stb = 1'b0;
                break;
            end
            if (v.n == 1 && (o_addr !== v.ea[3:0] || o_data !== v.ed[7:0])) digit_bad++;
            @(negedge i_clk);
        end
        i_stb = 1'b0;
        check({tag, " done_in_time"}, done, 1'b1);
        check({tag, " ack"}, o_ack, 1'b1);
        repeat (8) @(negedge i_clk);
        check({tag, " write_count"}, log_addr.size(), v.n);
        for (int i = 0; i < v.n; i++) begin
            ea = v.ea[i*4 +: 4];
            ed = v.ed[i*8 +: 8];
            if (i < log_addr.size())
                check($sformatf("%s write%0d", tag, i), {log_addr[i], log_data[i]}, {ea, ed});
            else
                check($sformatf("%s write%0d_missing", tag, i), 1'b0, 1'b1);
        end
        check({tag, " addr_data_stable"}, stable_bad, 0);
        if (v.n == 1) check({tag, " digit_held_busy"}, digit_bad, 0);
        check({tag, " idle_after"}, o_busy, 1'b0);
    endtask

    vec_t vecs[7];
    vec_t vrst;

    initial begin
        vecs[0] = mk(1, 0, 8'h00, 8'h0F, 4'd7, 3'd5, 1, 0, NCFG,
                     {4'hF, 4'hC, 4'hB, 4'hA, 4'h9}, {8'h00, 8'h01, 8'h05, 8'h07, 8'h0F});
        vecs[1] = mk(0, 0, 8'h0F, 8'h00, 4'd0, 3'd0, 0, 0, 1, 20'h1, 40'h0F);
        vecs[2] = mk(0, 1, 8'h07, 8'h00, 4'd0, 3'd0, 0, 0, 1, 20'h2, 40'h07);
        vecs[3] = mk(0, 2, 8'h05, 8'h00, 4'd0, 3'd0, 0, 0, 1, 20'h3, 40'h05);
        vecs[4] = mk(0, 3, 8'h01, 8'h00, 4'd0, 3'd0, 0, 0, 1, 20'h4, 40'h01);
        vecs[5] = mk(1, 0, 8'h00, 8'hFF, 4'hA, 3'd7, 0, 1, NCFG,
                     {4'hF, 4'hC, 4'hB, 4'hA, 4'h9}, {8'h01, 8'h00, 8'h07, 8'h0A, 8'hFF});
        vecs[6] = mk(0, 7, 8'hA5, 8'h00, 4'd0, 3'd0, 0, 0, 1, 20'h8, 40'hA5);
        vrst    = mk(0, 7, 8'h03, 8'h00, 4'd0, 3'd0, 0, 0, 1, 20'h8, 40'h03);

        i_reset = 1'b1; i_stb = 1'b0; i_digit = 3'd0; i_segment = 8'h00;
        i_write_config = 1'b0; i_decode_mode = 8'h00; i_intensity = 4'h0;
        i_scan_limit = 3'd0; i_enable = 1'b0; i_display_test = 1'b0;
        repeat (3) @(negedge i_clk);
        check("reset busy", o_busy, 1'b0);
        check("reset ack", o_ack, 1'b0);
        check("reset write", o_write, 1'b0);
        check("reset addr", o_addr, 4'h0);
        check("reset data", o_data, 8'h00);

        // Release reset and request on the very same negedge: first edge must accept.
        i_reset = 1'b0;
        for (int k = 0; k < 7; k++) run_op(vecs[k], 1'b0, $sformatf("vec%0d", k));

        // i_next while idle must not disturb anything.
        #1 manual_next = 1'b1;
        @(negedge i_clk);
        #1 manual_next = 1'b0;
        repeat (4) @(negedge i_clk);
        check("idle_next busy", o_busy, 1'b0);
        check("idle_next ack", o_ack, 1'b1);
        check("idle_next write", o_write, 1'b0);
        check("idle_next addr_data", {o_addr, o_data}, {4'h8, 8'hA5});
        check("idle_next writes", log_addr.size(), 1);

        // i_stb held for the whole operation: exactly one operation.
        run_op(vecs[1], 1'b1, "hold_digit");
        run_op(vecs[0], 1'b1, "hold_cfg");

        // Reset while waiting for the 0xB ack.
        log_addr.delete();
        log_data.delete();
        i_write_config = 1'b1; i_decode_mode = 8'h0F; i_intensity = 4'd7;
        i_scan_limit = 3'd5; i_enable = 1'b1; i_display_test = 1'b0;
        i_stb = 1'b1;
        @(negedge i_clk);
        i_stb = 1'b0;
        begin
            bit reached;
            reached = 0;
            for (int c = 0; c < 200; c++) begin
                @(negedge i_clk);
                if (log_addr.size() == 3 && o_write === 1'b0 && o_busy === 1'b1) begin
                    reached = 1;
                    break;
                end
            end
            check("midop reached_0xB_wait", reached, 1'b1);
        end
        check("midop third_write_addr", log_addr.size() >= 3 ? log_addr[2] : 4'h0, 4'hB);
        #2 i_reset = 1'b1;
        #1;
        check("midop reset busy", o_busy, 1'b0);
        check("midop reset ack", o_ack, 1'b0);
        check("midop reset write", o_write, 1'b0);
        check("midop reset addr_data", {o_addr, o_data}, 12'h000);
        @(negedge i_clk);
        i_reset = 1'b0;
        run_op(vrst, 1'b0, "after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
